// File: rtl/gmii_rx_ptp_parser_if.sv
// GMII receive stream plus the parser's per-frame PTP result bus.
// master: PHY/BFM side. slave: parser side.
interface gmii_rx_ptp_parser_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;

  logic              gmii_rxctrl;
  logic [BYTE_W-1:0] gmii_rxdata;
  logic              rx_sfd;
  logic              rx_eof;
  logic [LEN_W-1:0]  rx_len;
  logic              rx_vlan;
  logic              rx_ptp;
  logic              rx_ptp_event;
  logic [NIB_W-1:0]  rx_ptp_msgtype;
  logic [WORD_W-1:0] rx_ptp_seqid;

  modport master (
    output gmii_rxctrl, gmii_rxdata,
    input  rx_sfd, rx_eof, rx_len, rx_vlan, rx_ptp, rx_ptp_event,
           rx_ptp_msgtype, rx_ptp_seqid
  );

  modport slave (
    input  gmii_rxctrl, gmii_rxdata,
    output rx_sfd, rx_eof, rx_len, rx_vlan, rx_ptp, rx_ptp_event,
           rx_ptp_msgtype, rx_ptp_seqid
  );
endinterface

// File: rtl/gmii_rx_ptp_parser.sv
// GMII RX parser: preamble/SFD detection, byte count, Ethernet II / single
// 802.1Q decode and PTPv2 messageType/sequenceId extraction at end of frame.
module gmii_rx_ptp_parser (
  input  logic                  gmii_rxclk,
  input  logic                  rst,
  gmii_rx_ptp_parser_if.slave   bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;

  localparam logic [BYTE_W-1:0] PRE_BYTE = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE = 8'hD5;
  localparam logic [WORD_W-1:0] ET_VLAN  = 16'h8100;
  localparam logic [WORD_W-1:0] ET_PTP   = 16'h88F7;

  localparam logic [LEN_W-1:0]  LEN_MAX     = 11'h7FF;
  localparam logic [LEN_W-1:0]  IDX_ET_HI   = 11'd12;
  localparam logic [LEN_W-1:0]  IDX_ET_LO   = 11'd13;
  localparam logic [LEN_W-1:0]  IDX_IET_HI  = 11'd16;
  localparam logic [LEN_W-1:0]  IDX_IET_LO  = 11'd17;
  localparam logic [LEN_W-1:0]  BASE_UNTAG  = 11'd14;
  localparam logic [LEN_W-1:0]  BASE_TAG    = 11'd18;
  localparam logic [LEN_W-1:0]  OFS_VER     = 11'd1;
  localparam logic [LEN_W-1:0]  OFS_SEQ_HI  = 11'd30;
  localparam logic [LEN_W-1:0]  OFS_SEQ_LO  = 11'd31;
  localparam logic [LEN_W-1:0]  OFS_PTP_MIN = 11'd32;

  localparam logic [NIB_W-1:0]  PTP_VERSION = 4'd2;
  localparam logic [NIB_W-1:0]  EVENT_LIMIT = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              ctrl;
  logic [BYTE_W-1:0] data;

  logic              sfd_c;
  logic              eof_c;
  logic              cap_c;

  logic [LEN_W-1:0]  cnt_q;
  logic [WORD_W-1:0] etype_q;
  logic [WORD_W-1:0] inner_q;
  logic [NIB_W-1:0]  msg_q;
  logic [NIB_W-1:0]  ver_q;
  logic [WORD_W-1:0] seq_q;

  logic              vlan_c;
  logic [LEN_W-1:0]  base_c;
  logic [WORD_W-1:0] type_c;
  logic              ptp_c;
  logic              event_c;

  logic              sfd_q;
  logic              eof_q;
  logic [LEN_W-1:0]  len_q;
  logic              vlan_q;
  logic              ptp_q;
  logic              event_q;
  logic [NIB_W-1:0]  msgtype_q;
  logic [WORD_W-1:0] seqid_q;

  assign ctrl = bus.gmii_rxctrl;
  assign data = bus.gmii_rxdata;

  // State register
  always_ff @(posedge gmii_rxclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl) begin
          state_d = (data == PRE_BYTE) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!ctrl) begin
          state_d = IDLE;
        end else if (data == SFD_BYTE) begin
          state_d = DATA;
        end else if (data != PRE_BYTE) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!ctrl) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!ctrl) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded strobes and capture enable
  always_comb begin
    sfd_c = 1'b0;
    eof_c = 1'b0;
    cap_c = 1'b0;
    case (state_q)
      PRE:  sfd_c = ctrl && (data == SFD_BYTE);
      DATA: begin
        cap_c = ctrl;
        eof_c = !ctrl;
      end
      default: ;
    endcase
  end

  // Header decode; the outer Ethertype is complete before the PTP base is reached
  always_comb begin
    vlan_c  = (etype_q == ET_VLAN);
    base_c  = vlan_c ? BASE_TAG : BASE_UNTAG;
    type_c  = vlan_c ? inner_q : etype_q;
    ptp_c   = (type_c == ET_PTP) && (ver_q == PTP_VERSION) &&
              (cnt_q >= LEN_W'(base_c + OFS_PTP_MIN));
    event_c = ptp_c && (msg_q < EVENT_LIMIT);
  end

  // Byte counter and header capture, cleared at each accepted SFD
  always_ff @(posedge gmii_rxclk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      etype_q <= '0;
      inner_q <= '0;
      msg_q   <= '0;
      ver_q   <= '0;
      seq_q   <= '0;
    end else if (sfd_c) begin
      cnt_q   <= '0;
      etype_q <= '0;
      inner_q <= '0;
      msg_q   <= '0;
      ver_q   <= '0;
      seq_q   <= '0;
    end else if (cap_c) begin
      if (cnt_q != LEN_MAX) begin
        cnt_q <= LEN_W'(cnt_q + 11'd1);
      end
      if (cnt_q == IDX_ET_HI)  etype_q[15:8] <= data;
      if (cnt_q == IDX_ET_LO)  etype_q[7:0]  <= data;
      if (cnt_q == IDX_IET_HI) inner_q[15:8] <= data;
      if (cnt_q == IDX_IET_LO) inner_q[7:0]  <= data;
      if (cnt_q == base_c)                         msg_q        <= data[3:0];
      if (cnt_q == LEN_W'(base_c + OFS_VER))       ver_q        <= data[3:0];
      if (cnt_q == LEN_W'(base_c + OFS_SEQ_HI))    seq_q[15:8]  <= data;
      if (cnt_q == LEN_W'(base_c + OFS_SEQ_LO))    seq_q[7:0]   <= data;
    end
  end

  // Registered strobes and end-of-frame result hold
  always_ff @(posedge gmii_rxclk or posedge rst) begin
    if (rst) begin
      sfd_q     <= 1'b0;
      eof_q     <= 1'b0;
      len_q     <= '0;
      vlan_q    <= 1'b0;
      ptp_q     <= 1'b0;
      event_q   <= 1'b0;
      msgtype_q <= '0;
      seqid_q   <= '0;
    end else begin
      sfd_q <= sfd_c;
      eof_q <= eof_c;
      if (eof_c) begin
        len_q     <= cnt_q;
        vlan_q    <= vlan_c;
        ptp_q     <= ptp_c;
        event_q   <= event_c;
        msgtype_q <= msg_q;
        seqid_q   <= seq_q;
      end
    end
  end

  assign bus.rx_sfd         = sfd_q;
  assign bus.rx_eof         = eof_q;
  assign bus.rx_len         = len_q;
  assign bus.rx_vlan        = vlan_q;
  assign bus.rx_ptp         = ptp_q;
  assign bus.rx_ptp_event   = event_q;
  assign bus.rx_ptp_msgtype = msgtype_q;
  assign bus.rx_ptp_seqid   = seqid_q;

endmodule

// File: tb/tb_gmii_rx_ptp_parser.sv
// Bench for gmii_rx_ptp_parser: directed test-plan frames followed by random
// frames checked against a byte-array reference model.
module tb_gmii_rx_ptp_parser;

  typedef logic [7:0] u8_t;
  typedef struct {
    int len;
    int vlan;
    int ptp;
    int ev;
    int msg;
    int seq;
  } exp_t;

  logic gmii_rxclk = 1'b0;
  logic rst = 1'b1;

  gmii_rx_ptp_parser_if bus();

  gmii_rx_ptp_parser dut (
    .gmii_rxclk (gmii_rxclk),
    .rst        (rst),
    .bus        (bus)
  );

  always #4 gmii_rxclk = ~gmii_rxclk;

  int cyc = 0;
  always @(posedge gmii_rxclk) cyc <= cyc + 1;

  // Strobe monitor
  int sfd_cnt = 0;
  int eof_cnt = 0;
  int both_cnt = 0;
  int sfd_cyc = -1;
  int eof_cyc = -1;
  int eof_seq_q[$];

  always @(negedge gmii_rxclk) begin
    if (bus.rx_sfd === 1'b1) begin
      sfd_cnt <= sfd_cnt + 1;
      sfd_cyc <= cyc;
    end
    if (bus.rx_eof === 1'b1) begin
      eof_cnt <= eof_cnt + 1;
      eof_cyc <= cyc;
      eof_seq_q.push_back(int'(bus.rx_ptp_seqid));
    end
    if (bus.rx_sfd === 1'b1 && bus.rx_eof === 1'b1) both_cnt <= both_cnt + 1;
  end

  int   total = 0;
  int   passed = 0;
  int   exp_sfd = 0;
  int   exp_eof = 0;
  int   d5_cyc = 0;
  int   end_cyc = 0;
  u8_t  frm[$];
  exp_t last_exp;
  exp_t zero_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t mk(int len, int vlan, int ptp, int ev, int msg, int seq);
    exp_t e;
    e.len = len; e.vlan = vlan; e.ptp = ptp; e.ev = ev; e.msg = msg; e.seq = seq;
    return e;
  endfunction

  // Byte i of the current frame, zero when the frame is shorter
  function automatic int at(int i);
    return (i < frm.size()) ? int'(frm[i]) : 0;
  endfunction

  // Reference model: expected results straight from the framing rules
  function automatic exp_t model();
    exp_t e;
    int n, et, p, ver, real_et;
    n       = frm.size();
    e.len   = (n > 2047) ? 2047 : n;
    et      = at(12) * 256 + at(13);
    e.vlan  = (et == 'h8100) ? 1 : 0;
    p       = (e.vlan != 0) ? 18 : 14;
    e.msg   = at(p) % 16;
    ver     = at(p + 1) % 16;
    e.seq   = at(p + 30) * 256 + at(p + 31);
    real_et = (e.vlan != 0) ? at(16) * 256 + at(17) : et;
    e.ptp   = (real_et == 'h88F7 && ver == 2 && n >= p + 32) ? 1 : 0;
    e.ev    = (e.ptp != 0 && e.msg < 4) ? 1 : 0;
    return e;
  endfunction

  task automatic setb(input int i, input u8_t v);
    if (i < frm.size()) frm[i] = v;
  endtask

  // kind: 0 random, 1 untagged PTP, 2 tagged PTP, 3 stacked tags, 4 IPv4
  task automatic build(input int n, input int kind, input u8_t bp, input u8_t bp1,
                       input logic [15:0] seq);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    case (kind)
      1: begin
        setb(12, 8'h88); setb(13, 8'hF7); setb(14, bp); setb(15, bp1);
        setb(44, seq[15:8]); setb(45, seq[7:0]);
      end
      2, 3: begin
        setb(12, 8'h81); setb(13, 8'h00);
        setb(16, (kind == 2) ? 8'h88 : 8'h81); setb(17, (kind == 2) ? 8'hF7 : 8'h00);
        setb(18, bp); setb(19, bp1); setb(48, seq[15:8]); setb(49, seq[7:0]);
      end
      4: begin
        setb(12, 8'h08); setb(13, 8'h00);
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic c, input u8_t d);
    @(posedge gmii_rxclk);
    #1;
    bus.gmii_rxctrl = c;
    bus.gmii_rxdata = d;
  endtask

  task automatic send(input int pre_n, input int gap);
    for (int i = 0; i < pre_n; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    d5_cyc = cyc;
    for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i]);
    drive(1'b0, 8'($urandom));
    end_cyc = cyc;
    for (int i = 1; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  task automatic settle();
    repeat (2) @(negedge gmii_rxclk);
    #1;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_len"},     32'(bus.rx_len),         32'(e.len));
    chk({tag, "_vlan"},    32'(bus.rx_vlan),        32'(e.vlan));
    chk({tag, "_ptp"},     32'(bus.rx_ptp),         32'(e.ptp));
    chk({tag, "_event"},   32'(bus.rx_ptp_event),   32'(e.ev));
    chk({tag, "_msgtype"}, 32'(bus.rx_ptp_msgtype), 32'(e.msg));
    chk({tag, "_seqid"},   32'(bus.rx_ptp_seqid),   32'(e.seq));
  endtask

  task automatic check_frame(input string tag, input exp_t e);
    exp_sfd++;
    exp_eof++;
    chk({tag, "_sfd_cnt"}, 32'(sfd_cnt), 32'(exp_sfd));
    chk({tag, "_eof_cnt"}, 32'(eof_cnt), 32'(exp_eof));
    chk({tag, "_sfd_lat"}, 32'(sfd_cyc), 32'(d5_cyc + 1));
    chk({tag, "_eof_lat"}, 32'(eof_cyc), 32'(end_cyc + 1));
    check_out(tag, e);
    last_exp = e;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_sfd_cnt"}, 32'(sfd_cnt), 32'(exp_sfd));
    chk({tag, "_eof_cnt"}, 32'(eof_cnt), 32'(exp_eof));
    check_out(tag, last_exp);
  endtask

  initial begin
    int n, kind, pre_n, gap, q0, q1;
    u8_t bp, bp1;
    logic [15:0] sq;

    zero_exp = mk(0, 0, 0, 0, 0, 0);
    last_exp = zero_exp;
    bus.gmii_rxctrl = 1'b0;
    bus.gmii_rxdata = 8'h00;

    // Reset values
    repeat (3) @(negedge gmii_rxclk);
    check_out("reset", zero_exp);
    chk("reset_sfd", 32'(bus.rx_sfd), 32'd0);
    chk("reset_eof", 32'(bus.rx_eof), 32'd0);
    rst = 1'b0;
    repeat (12) drive(1'b0, 8'h00);

    // Untagged Sync
    build(86, 1, 8'h00, 8'h02, 16'h1234);
    send(7, 1); settle();
    check_frame("sync", mk(86, 0, 1, 1, 0, 'h1234));

    // VLAN-tagged Follow_Up
    build(90, 2, 8'h08, 8'h02, 16'hBEEF);
    send(7, 1); settle();
    check_frame("vlan_fu", mk(90, 1, 1, 0, 8, 'hBEEF));

    // IPv4 frame
    build(64, 4, 8'h00, 8'h02, 16'h0000);
    send(7, 1); settle();
    chk("ipv4_len_plan", 32'(bus.rx_len), 32'd64);
    check_frame("ipv4", model());

    // Truncated PTP frame: sequenceId bytes never arrive
    build(40, 1, 8'h00, 8'h02, 16'hFFFF);
    send(7, 1); settle();
    check_frame("trunc", mk(40, 0, 0, 0, 0, 0));

    // Preamble corrupted by 0xAA
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'hAA);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom));
    drive(1'b0, 8'h00); drive(1'b0, 8'h00);
    settle();
    check_quiet("pre_err");

    // Lone SFD from IDLE
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom));
    drive(1'b0, 8'h00); drive(1'b0, 8'h00);
    settle();
    check_quiet("lone_sfd");

    // Stacked VLAN tags are not decoded as PTP
    build(90, 3, 8'h00, 8'h02, 16'h4321);
    send(7, 1); settle();
    check_frame("stacked", mk(90, 1, 0, 0, 0, 'h4321));

    // Zero-length frame
    frm.delete();
    send(7, 1); settle();
    check_frame("zero_len", zero_exp);

    // Back-to-back Sync frames with a single idle cycle
    eof_seq_q.delete();
    build(86, 1, 8'h00, 8'h02, 16'h0001);
    send(7, 1);
    exp_sfd++; exp_eof++;
    build(86, 1, 8'h00, 8'h02, 16'h0002);
    send(7, 1); settle();
    check_frame("b2b", mk(86, 0, 1, 1, 0, 'h0002));
    chk("b2b_eof_q_size", 32'(eof_seq_q.size()), 32'd2);
    q0 = (eof_seq_q.size() >= 2) ? eof_seq_q[0] : -1;
    q1 = (eof_seq_q.size() >= 2) ? eof_seq_q[1] : -1;
    chk("b2b_seq_first", 32'(q0), 32'd1);
    chk("b2b_seq_second", 32'(q1), 32'd2);

    // Reset asserted at byte 20 of a PTP frame, released with ctrl still high
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    exp_sfd++;
    for (int i = 0; i < 20; i++)
      drive(1'b1, (i == 12) ? 8'h88 : (i == 13) ? 8'hF7 : (i == 15) ? 8'h02 : 8'hA0);
    #2 rst = 1'b1;
    #1;
    check_out("rst_mid", zero_exp);
    drive(1'b1, 8'hA0); drive(1'b1, 8'hA0);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hA0);
    repeat (3) drive(1'b0, 8'h00);
    settle();
    last_exp = zero_exp;
    check_quiet("rst_after");

    build(86, 1, 8'h01, 8'h02, 16'h0777);
    send(7, 1); settle();
    check_frame("post_rst", mk(86, 0, 1, 1, 1, 'h0777));

    // Length saturation
    build(2100, 1, 8'h03, 8'h02, 16'hCAFE);
    send(7, 2); settle();
    check_frame("saturate", mk(2047, 0, 1, 1, 3, 'hCAFE));

    // Random frames against the reference model
    for (int k = 0; k < 40; k++) begin
      n     = int'($urandom_range(0, 110));
      kind  = int'($urandom_range(0, 4));
      bp    = 8'($urandom);
      bp1   = ($urandom_range(0, 1) == 1) ? {4'($urandom), 4'h2} : 8'($urandom);
      sq    = 16'($urandom);
      pre_n = int'($urandom_range(1, 7));
      gap   = int'($urandom_range(1, 3));
      build(n, kind, bp, bp1, sq);
      send(pre_n, gap); settle();
      check_frame($sformatf("rnd%0d", k), model());
    end

    chk("sfd_eof_overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gmii_rx_ptp_parser.md
# gmii_rx_ptp_parser

Synthesizable receive-side parser that consumes the GMII receive stream (gmii_rxctrl/gmii_rxdata) produced by the PHY or the GMII RX bus-functional model. It detects the preamble/SFD, emits an SFD strobe for timestamp capture, and counts frame bytes. It decodes Ethernet II framing with an optional single 802.1Q tag and reports PTPv2 (Ethertype 0x88F7) messageType and sequenceId at end of frame. It feeds the RX timestamp unit and the RX timestamp queue.

## Interface
- No parameters.
- gmii_rxclk  in  1  receive clock; all inputs sampled and all outputs updated on its rising edge
- rst  in  1  asynchronous, active-high reset
- gmii_rxctrl  in  1  receive data valid (RX_DV)
- gmii_rxdata  in  8  receive byte
- rx_sfd  out  1  one-cycle strobe: SFD accepted
- rx_eof  out  1  one-cycle strobe: frame ended; result outputs valid from this cycle on
- rx_len  out  11  bytes after SFD, saturating at 2047
- rx_vlan  out  1  frame carried 0x8100 tag
- rx_ptp  out  1  frame is a well-formed PTPv2 message
- rx_ptp_event  out  1  rx_ptp and messageType < 4 (Sync, Delay_Req, Pdelay_Req, Pdelay_Resp)
- rx_ptp_msgtype  out  4  PTP messageType
- rx_ptp_seqid  out  16  PTP sequenceId, big-endian

## Operation
- States: IDLE, PRE, DATA, DROP.
- IDLE:
  - ctrl=1, data=0x55 -> PRE.
  - ctrl=1 with any other data -> DROP.
  - ctrl=0 -> stay.
- PRE:
  - ctrl=1, data=0x55 -> stay.
  - ctrl=1, data=0xD5 -> DATA; pulse rx_sfd; clear byte counter and parse registers.
  - ctrl=1 with any other data -> DROP.
  - ctrl=0 -> IDLE, no strobes.
- DATA:
  - ctrl=1 -> capture byte at index b (0-based after SFD), then b increments (counter saturates at 2047).
  - ctrl=0 -> IDLE; pulse rx_eof; load the result outputs.
- DROP: wait for ctrl=0 -> IDLE. No strobes and no output updates.
- Parsing, by index b:
  - Bytes 12..13 form the Ethertype.
  - If the Ethertype is 0x8100: vlan=1, the real Ethertype is bytes 16..17, and PTP base p=18. Otherwise p=14.
  - msgtype = byte p [3:0].
  - version = byte p+1 [3:0].
  - seqid = {byte p+30, byte p+31}.
  - Bytes beyond p+31 are counted only.
- rx_ptp = (Ethertype==0x88F7) && (version==2) && (rx_len >= p+32). If the frame ends before byte p+31, rx_ptp=0 and rx_ptp_seqid holds whatever bytes were captured (zeros for uncaptured bytes).
- rx_len, rx_vlan, rx_ptp, rx_ptp_event, rx_ptp_msgtype and rx_ptp_seqid update only on the rx_eof edge and hold until the next rx_eof.
- Only a single VLAN tag is decoded. Stacked tags (0x8100 at bytes 16..17) give rx_ptp=0.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset is asynchronous. Asserting rst mid-frame forces IDLE and zeroes all outputs immediately, with no rx_eof.
- After release, if ctrl is still high mid-frame, the first byte seen is non-0x55, so the block enters DROP and that frame is discarded.
- rx_sfd is high for exactly the cycle after the edge that samples 0xD5, i.e. a latency of 1 clock from SFD on the pins.
- rx_eof is high for exactly the cycle after the first edge that samples ctrl=0 in DATA. The result outputs change on that same edge.
- The minimum gap is 1 idle cycle. A preamble starting on the edge right after the ctrl=0 edge is accepted normally, so rx_eof and the next frame's PRE entry overlap legally.
- An SFD with no preceding 0x55 (IDLE sees 0xD5) -> DROP.
- rx_sfd and rx_eof are never high in the same cycle.
- A zero-length frame (ctrl falls right after the SFD) gives rx_eof with rx_len=0 and rx_ptp=0.

## Test plan
- Untagged Sync:
  - Stimulus: 12 idle cycles, 7×0x55 + 0xD5, then 86 bytes with Ethertype 0x88F7, byte14=0x00, byte15=0x02, bytes44..45=0x12,0x34.
  - Response: one rx_sfd 1 cycle after D5; rx_eof 1 cycle after ctrl falls; rx_len=86, rx_ptp=1, rx_ptp_event=1, msgtype=0, seqid=0x1234, vlan=0.
- VLAN-tagged Follow_Up:
  - Stimulus: bytes12..13=0x8100, 16..17=0x88F7, byte18=0x08, byte19=0x02, bytes48..49=0xBEEF, length 90.
  - Response: rx_vlan=1, rx_ptp=1, rx_ptp_event=0, msgtype=8, seqid=0xBEEF, rx_len=90.
- Non-PTP and truncated frames:
  - Stimulus A: IPv4 frame (0x0800), 64 bytes. Response: rx_ptp=0, rx_len=64.
  - Stimulus B: 0x88F7 frame of 40 bytes. Response: rx_ptp=0, rx_len=40.
- Preamble errors:
  - Stimulus A: preamble 0x55,0x55,0xAA,... then data. Response: no rx_sfd, no rx_eof, outputs unchanged.
  - Stimulus B: a lone 0xD5 from IDLE. Response: no rx_sfd, no rx_eof, outputs unchanged.
- Back-to-back frames: two Sync frames (seqid 1 and 2) separated by 1 idle cycle -> two rx_sfd and two rx_eof, with seqid 1 then 2.
- Reset mid-frame:
  - Stimulus: assert rst at byte 20 of a PTP frame, release while ctrl is still high.
  - Response: outputs 0 immediately; no rx_eof for that frame; the next well-formed frame parses correctly.
